// File: rtl/elevator_pkg.sv
// Shared types and default timing for the single-car elevator call scheduler.
// Imported by the input conditioner and the scheduler top.
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR      = 2'd3
   } car_state_t;

   localparam int DEF_NUM_FLOORS    = 4;
   localparam int DEF_TRAVEL_CYCLES = 8;
   localparam int DEF_DOOR_CYCLES   = 4;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/call_input_conditioner.sv
// Two-flop synchronizer plus a third flop for rising-edge detection of one call button.
// A button held through reset is seen as a fresh press once reset releases.
module call_input_conditioner
   import elevator_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic s3_q, s3_d;

   always_comb begin
      s1_d = btn;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/elevator_call_scheduler.sv
// Single-car SCAN scheduler: latches conditioned floor calls as pending requests and
// drives car position, motion, direction and door state from one shared timer.
module elevator_call_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
   parameter int FLOOR_W       = $clog2(NUM_FLOORS),
   parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
   parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
)
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] call_btn,
   output logic [FLOOR_W-1:0]    cur_floor,
   output logic                  moving,
   output logic                  dir_up,
   output logic                  door_open,
   output logic                  arrive,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int TIMER_W = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
   localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

   car_state_t              state_q, state_d;
   logic [FLOOR_W-1:0]      cur_floor_q, cur_floor_d;
   logic                    dir_up_q, dir_up_d;
   logic [TIMER_W-1:0]      timer_q, timer_d;
   logic                    arrive_q, arrive_d;
   logic [NUM_FLOORS-1:0]   pending_q, pending_d;

   logic [NUM_FLOORS-1:0]   rise;
   logic [NUM_FLOORS-1:0]   above, below;
   logic [NUM_FLOORS-1:0]   cur_onehot, up_onehot, dn_onehot, arr_onehot;
   logic [NUM_FLOORS-1:0]   clr, latch_mask;
   logic                    ahead_any, behind_any;

   for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_cond
      call_input_conditioner u_cond (
         .clock (clock),
         .reset (reset),
         .btn   (call_btn[f]),
         .rise  (rise[f])
      );
   end

   // Requests split by position relative to the car, plus one-hot floor selects.
   always_comb begin
      above      = '0;
      below      = '0;
      cur_onehot = '0;
      up_onehot  = '0;
      dn_onehot  = '0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
         above[f]      = (f > int'(cur_floor_q)) && pending_q[f];
         below[f]      = (f < int'(cur_floor_q)) && pending_q[f];
         cur_onehot[f] = (f == int'(cur_floor_q));
         up_onehot[f]  = (f == int'(cur_floor_q) + 1);
         dn_onehot[f]  = (f == int'(cur_floor_q) - 1);
      end
      ahead_any  = dir_up_q ? |above : |below;
      behind_any = dir_up_q ? |below : |above;
   end

   always_comb begin
      state_d     = state_q;
      cur_floor_d = cur_floor_q;
      dir_up_d    = dir_up_q;
      timer_d     = timer_q;
      arrive_d    = 1'b0;
      arr_onehot  = '0;
      clr         = '0;
      latch_mask  = rise;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (|(pending_q & cur_onehot)) begin
               state_d = DOOR;
               clr     = cur_onehot;
            end else if (ahead_any) begin
               state_d = dir_up_q ? MOVE_UP : MOVE_DOWN;
            end else if (behind_any) begin
               dir_up_d = ~dir_up_q;
               state_d  = dir_up_q ? MOVE_DOWN : MOVE_UP;
            end
         end
         MOVE_UP, MOVE_DOWN: begin
            if (timer_q == TRAVEL_LAST) begin
               timer_d  = '0;
               arrive_d = 1'b1;
               if (state_q == MOVE_UP) begin
                  cur_floor_d = cur_floor_q + 1'b1;
                  arr_onehot  = up_onehot;
               end else begin
                  cur_floor_d = cur_floor_q - 1'b1;
                  arr_onehot  = dn_onehot;
               end
               // Stop only where a request waits; otherwise keep sweeping.
               if (|(pending_q & arr_onehot)) begin
                  state_d = DOOR;
                  clr     = arr_onehot;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DOOR: begin
            // A press for the open floor holds the door rather than queueing a request.
            latch_mask = rise & ~cur_onehot;
            if (|(rise & cur_onehot)) begin
               timer_d = '0;
            end else if (timer_q == DOOR_LAST) begin
               timer_d = '0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      pending_d = (pending_q | latch_mask) & ~clr;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cur_floor_q <= '0;
         dir_up_q    <= 1'b1;
         timer_q     <= '0;
         arrive_q    <= 1'b0;
         pending_q   <= '0;
      end else begin
         state_q     <= state_d;
         cur_floor_q <= cur_floor_d;
         dir_up_q    <= dir_up_d;
         timer_q     <= timer_d;
         arrive_q    <= arrive_d;
         pending_q   <= pending_d;
      end
   end

   assign cur_floor = cur_floor_q;
   assign moving    = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
   assign dir_up    = dir_up_q;
   assign door_open = (state_q == DOOR);
   assign arrive    = arrive_q;
   assign pending   = pending_q;

   // The car must never leave the shaft.
   assert property (@(posedge clock) disable iff (reset) cur_floor_q <= TOP_FLOOR);
   assert property (@(posedge clock) disable iff (reset) !(state_q == MOVE_UP && cur_floor_q == TOP_FLOOR));
   assert property (@(posedge clock) disable iff (reset) !(state_q == MOVE_DOWN && cur_floor_q == '0));

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: vector table for the main sweeps, plus
// hand-written sequences for held buttons, mid-travel reset and all-floor calls.
module tb_elevator_call_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] call_btn = 4'b0000;
   logic [1:0] cur_floor;
   logic       moving, dir_up, door_open, arrive;
   logic [3:0] pending;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0] btn;
      int         ticks;
      logic [1:0] floor;
      logic       mov;
      logic       dir;
      logic       door;
      logic       arr;
      logic [3:0] pend;
   } vec_t;

   vec_t vecs[$];

   always #5 clock = ~clock;

   elevator_call_scheduler #(
      .NUM_FLOORS    (4),
      .FLOOR_W       (2),
      .TRAVEL_CYCLES (8),
      .DOOR_CYCLES   (4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .call_btn  (call_btn),
      .cur_floor (cur_floor),
      .moving    (moving),
      .dir_up    (dir_up),
      .door_open (door_open),
      .arrive    (arrive),
      .pending   (pending)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [1:0] fl, input logic mv, input logic dr,
                           input logic dor, input logic ar, input logic [3:0] pd);
      chk({tag, " cur_floor"}, cur_floor, fl);
      chk({tag, " moving"}, moving, mv);
      chk({tag, " dir_up"}, dir_up, dr);
      chk({tag, " door_open"}, door_open, dor);
      chk({tag, " arrive"}, arrive, ar);
      chk({tag, " pending"}, pending, pd);
   endtask

   task automatic add(input logic [3:0] b, input int t, input logic [1:0] fl, input logic mv,
                      input logic dr, input logic dor, input logic ar, input logic [3:0] pd);
      vec_t v;
      v.btn = b; v.ticks = t; v.floor = fl; v.mov = mv;
      v.dir = dr; v.door = dor; v.arr = ar; v.pend = pd;
      vecs.push_back(v);
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         call_btn = vecs[i].btn;
         repeat (vecs[i].ticks) tick();
         chk_outs($sformatf("vec%0d", i), vecs[i].floor, vecs[i].mov, vecs[i].dir,
                  vecs[i].door, vecs[i].arr, vecs[i].pend);
      end
      call_btn = 4'b0000;
   endtask

   initial begin
      int a_end, c_end, d_end;
      int arr_cnt, door_rise, door_cyc, max_floor;
      logic prev_door;
      logic [1:0] door_seq [4];

      // Call floor 2 from floor 0: two 8-cycle hops, 4-cycle door.
      add(4'b0100, 1, 2'd0, 0, 1, 0, 0, 4'b0000);
      add(4'b0000, 1, 2'd0, 0, 1, 0, 0, 4'b0000);
      add(4'b0000, 1, 2'd0, 0, 1, 0, 0, 4'b0100);
      add(4'b0000, 1, 2'd0, 1, 1, 0, 0, 4'b0100);
      add(4'b0000, 7, 2'd0, 1, 1, 0, 0, 4'b0100);
      add(4'b0000, 1, 2'd1, 1, 1, 0, 1, 4'b0100);
      add(4'b0000, 1, 2'd1, 1, 1, 0, 0, 4'b0100);
      add(4'b0000, 7, 2'd2, 0, 1, 1, 1, 4'b0000);
      add(4'b0000, 3, 2'd2, 0, 1, 1, 0, 4'b0000);
      add(4'b0000, 1, 2'd2, 0, 1, 0, 0, 4'b0000);
      add(4'b0000, 4, 2'd2, 0, 1, 0, 0, 4'b0000);
      a_end = vecs.size();
      // From floor 3 call floor 0 (reverse), then re-press 0 while the door is open.
      add(4'b0001, 1, 2'd3, 0, 1, 0, 0, 4'b0000);
      add(4'b0000, 1, 2'd3, 0, 1, 0, 0, 4'b0000);
      add(4'b0000, 1, 2'd3, 0, 1, 0, 0, 4'b0001);
      add(4'b0000, 1, 2'd3, 1, 0, 0, 0, 4'b0001);
      add(4'b0000, 8, 2'd2, 1, 0, 0, 1, 4'b0001);
      add(4'b0000, 8, 2'd1, 1, 0, 0, 1, 4'b0001);
      add(4'b0000, 8, 2'd0, 0, 0, 1, 1, 4'b0000);
      add(4'b0000, 1, 2'd0, 0, 0, 1, 0, 4'b0000);
      add(4'b0001, 1, 2'd0, 0, 0, 1, 0, 4'b0000);
      add(4'b0000, 1, 2'd0, 0, 0, 1, 0, 4'b0000);
      add(4'b0000, 1, 2'd0, 0, 0, 1, 0, 4'b0000);
      add(4'b0000, 3, 2'd0, 0, 0, 1, 0, 4'b0000);
      add(4'b0000, 1, 2'd0, 0, 0, 0, 0, 4'b0000);
      add(4'b0000, 3, 2'd0, 0, 0, 0, 0, 4'b0000);
      c_end = vecs.size();
      // Heading 0 -> 3, calls for 0 and 2 made at floor 1: stops 2, 3, then back down to 0.
      add(4'b1000, 1, 2'd0, 0, 0, 0, 0, 4'b0000);
      add(4'b0000, 1, 2'd0, 0, 0, 0, 0, 4'b0000);
      add(4'b0000, 1, 2'd0, 0, 0, 0, 0, 4'b1000);
      add(4'b0000, 1, 2'd0, 1, 1, 0, 0, 4'b1000);
      add(4'b0000, 8, 2'd1, 1, 1, 0, 1, 4'b1000);
      add(4'b0101, 1, 2'd1, 1, 1, 0, 0, 4'b1000);
      add(4'b0000, 1, 2'd1, 1, 1, 0, 0, 4'b1000);
      add(4'b0000, 1, 2'd1, 1, 1, 0, 0, 4'b1101);
      add(4'b0000, 5, 2'd2, 0, 1, 1, 1, 4'b1001);
      add(4'b0000, 4, 2'd2, 0, 1, 0, 0, 4'b1001);
      add(4'b0000, 1, 2'd2, 1, 1, 0, 0, 4'b1001);
      add(4'b0000, 8, 2'd3, 0, 1, 1, 1, 4'b0001);
      add(4'b0000, 4, 2'd3, 0, 1, 0, 0, 4'b0001);
      add(4'b0000, 1, 2'd3, 1, 0, 0, 0, 4'b0001);
      add(4'b0000, 8, 2'd2, 1, 0, 0, 1, 4'b0001);
      add(4'b0000, 8, 2'd1, 1, 0, 0, 1, 4'b0001);
      add(4'b0000, 8, 2'd0, 0, 0, 1, 1, 4'b0000);
      add(4'b0000, 4, 2'd0, 0, 0, 0, 0, 4'b0000);
      d_end = vecs.size();

      // Reset, then 20 quiet cycles.
      reset = 1'b1;
      tick();
      tick();
      chk_outs("reset", 2'd0, 0, 1, 0, 0, 4'b0000);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_outs($sformatf("idle%0d", i), 2'd0, 0, 1, 0, 0, 4'b0000);
      end

      run_vecs(0, a_end);

      // Hold floor 3 for 30 cycles from floor 2: exactly one request and one stop.
      arr_cnt = 0; door_rise = 0; door_cyc = 0; prev_door = 1'b0;
      call_btn = 4'b1000;
      for (int i = 1; i <= 40; i++) begin
         if (i == 31) call_btn = 4'b0000;
         tick();
         if (arrive) arr_cnt++;
         if (door_open) door_cyc++;
         if (door_open && !prev_door) door_rise++;
         prev_door = door_open;
         if (i == 3) chk("hold pend", pending, 4'b1000);
         if (i == 12) chk("hold arrive floor", cur_floor, 2'd3);
      end
      chk("hold arrive count", arr_cnt, 1);
      chk("hold door entries", door_rise, 1);
      chk("hold door cycles", door_cyc, 4);
      chk_outs("hold end", 2'd3, 0, 1, 0, 0, 4'b0000);

      run_vecs(a_end, c_end);
      run_vecs(c_end, d_end);

      // Reset between floors 1 and 2 while floor 3 is held.
      call_btn = 4'b1000;
      repeat (3) tick();
      chk("rst pend", pending, 4'b1000);
      tick();
      chk("rst moving", moving, 1'b1);
      repeat (8) tick();
      chk("rst floor1", cur_floor, 2'd1);
      repeat (3) tick();
      chk("rst midtravel", moving, 1'b1);
      reset = 1'b1;
      tick();
      chk_outs("rst applied", 2'd0, 0, 1, 0, 0, 4'b0000);
      tick();
      reset = 1'b0;
      repeat (2) tick();
      chk_outs("rst settle", 2'd0, 0, 1, 0, 0, 4'b0000);
      tick();
      chk("rst rerequest", pending, 4'b1000);
      tick();
      chk("rst remove", moving, 1'b1);
      call_btn = 4'b0000;
      repeat (30) tick();
      chk_outs("rst served", 2'd3, 0, 1, 0, 0, 4'b0000);

      // All floors at once from floor 0.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      arr_cnt = 0; door_rise = 0; max_floor = 0; prev_door = 1'b0;
      for (int k = 0; k < 4; k++) door_seq[k] = 2'd0;
      call_btn = 4'b1111;
      tick();
      call_btn = 4'b0000;
      for (int i = 2; i <= 60; i++) begin
         tick();
         if (arrive) arr_cnt++;
         if (int'(cur_floor) > max_floor) max_floor = int'(cur_floor);
         if (door_open && !prev_door) begin
            if (door_rise < 4) door_seq[door_rise] = cur_floor;
            door_rise++;
         end
         prev_door = door_open;
         if (i == 3) chk("all pend", pending, 4'b1111);
         if (i == 4) chk("all first door pend", pending, 4'b1110);
      end
      chk("all door count", door_rise, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("all door order %0d", k), door_seq[k], k);
      chk("all arrive count", arr_cnt, 3);
      chk("all max floor", max_floor, 3);
      chk_outs("all end", 2'd3, 0, 1, 0, 0, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
